// File: rtl/mem_arbiter.sv
// Three-port arbiter for a single-port synchronous memory (fetch, load/store, debug).
// Optional per-port grant counters are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    output logic [2:0]          gnt,
    output logic [2:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
`ifdef MEM_ARB_STATS_EN
    output logic [3*16-1:0]     stat_cnt,
`endif
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [1:0]          winner_q;
    logic                we_q;
    logic [3:0]          starve_q;
    logic [2:0]          gnt_q;
    logic [2:0]          rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic [1:0]          winner_d;
    logic [3:0]          starve_d;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Arbitration: debug escape first, then port1 > port0 > port2.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        winner_d  = winner_q;
        starve_d  = starve_q;
        sel_we    = we[0];
        sel_addr  = addr[0 +: ADDR_W];
        sel_wdata = wdata[0 +: DATA_W];

        if (req[2] && (starve_q >= 4'(STARVE_LIMIT))) winner_d = 2'd2;
        else if (req[1])                              winner_d = 2'd1;
        else if (req[0])                              winner_d = 2'd0;
        else if (req[2])                              winner_d = 2'd2;

        if (!req[2] || (winner_d == 2'd2)) starve_d = 4'd0;
        else if (starve_q != 4'hF)          starve_d = starve_q + 4'd1;

        case (winner_d)
            2'd1: begin
                sel_we    = we[1];
                sel_addr  = addr[ADDR_W +: ADDR_W];
                sel_wdata = wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                sel_we    = we[2];
                sel_addr  = addr[2*ADDR_W +: ADDR_W];
                sel_wdata = wdata[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            winner_q    <= 2'd0;
            we_q        <= 1'b0;
            starve_q    <= 4'd0;
            gnt_q       <= 3'b000;
            rvalid_q    <= 3'b000;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_RESP: begin
                    rvalid_q <= 3'b000;
                    if ((state_q == S_RESP) && !we_q) rdata_q <= mem_rdata;
                    starve_q <= starve_d;
                    if (|req) begin
                        state_q     <= S_ISSUE;
                        winner_q    <= winner_d;
                        we_q        <= sel_we;
                        gnt_q       <= 3'b001 << winner_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    state_q  <= S_RESP;
                    gnt_q    <= 3'b000;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    rvalid_q <= 3'b001 << winner_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    // The memory's registered output arrives in the RESP cycle itself, so it bypasses rdata_q.
    assign rdata     = ((state_q == S_RESP) && !we_q) ? mem_rdata : rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [2:0][15:0] stat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q <= '0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (gnt_q[n] && (stat_q[n] != 16'hFFFF)) stat_q[n] <= stat_q[n] + 16'd1;
            end
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 registered-read memory.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [23:0] addr;
    logic [23:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [7:0]  rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [47:0] stat_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef MEM_ARB_STATS_EN
        .stat_cnt  (stat_cnt),
`endif
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents: word i holds i ^ 8'h5A, except word 8'h10 holds 8'hA5.
    logic [7:0] mem [256];
    logic       mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 8'hA5 : (8'(i) ^ 8'h5A);
            mem_init_done <= 1'b1;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic set_cmd(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        we[p]          = w;
        addr[p*8 +: 8] = a;
        wdata[p*8 +: 8] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 3'b000; we = 3'b000; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (gnt !== 3'b000)    begin n_bad++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        n_cmp++; if (rvalid !== 3'b000) begin n_bad++; $display("FAIL reset_rvalid: got %b want 000", rvalid); end
        n_cmp++; if (mem_en !== 1'b0)   begin n_bad++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        n_cmp++; if (mem_we !== 1'b0)   begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (rdata !== 8'h00)   begin n_bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_cmp++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00)
            begin n_bad++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 00 00", mem_addr, mem_wdata); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        set_cmd(0, 1'b0, 8'h10, 8'h00);
        req = 3'b001;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001)    begin n_bad++; $display("FAIL rd_gnt: got %b want 001", gnt); end
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10)
            begin n_bad++; $display("FAIL rd_mem_bus: got en %b we %b addr %h want 1 0 10", mem_en, mem_we, mem_addr); end
        n_cmp++; if (rvalid !== 3'b000) begin n_bad++; $display("FAIL rd_early_rvalid: got %b want 000", rvalid); end
        req = 3'b000;
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b001) begin n_bad++; $display("FAIL rd_rvalid: got %b want 001", rvalid); end
        n_cmp++; if (rdata !== 8'hA5)   begin n_bad++; $display("FAIL rd_rdata: got %h want a5", rdata); end
        n_cmp++; if (gnt !== 3'b000 || mem_en !== 1'b0)
            begin n_bad++; $display("FAIL rd_gnt_pulse: got gnt %b en %b want 000 0", gnt, mem_en); end
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b000) begin n_bad++; $display("FAIL rd_rvalid_pulse: got %b want 000", rvalid); end
        n_cmp++; if (rdata !== 8'hA5)   begin n_bad++; $display("FAIL rd_rdata_hold: got %h want a5", rdata); end
    endtask

    task automatic test_write_read();
        set_cmd(1, 1'b1, 8'h20, 8'h3C);
        req = 3'b010;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b010)    begin n_bad++; $display("FAIL wr_gnt: got %b want 010", gnt); end
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h3C)
            begin n_bad++; $display("FAIL wr_mem_bus: got we %b addr %h data %h want 1 20 3c", mem_we, mem_addr, mem_wdata); end
        set_cmd(1, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b010) begin n_bad++; $display("FAIL wr_ack: got %b want 010", rvalid); end
        n_cmp++; if (rdata !== 8'hA5)   begin n_bad++; $display("FAIL wr_rdata_hold: got %h want a5", rdata); end
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b010 || mem_we !== 1'b0)
            begin n_bad++; $display("FAIL wrrd_gnt: got gnt %b we %b want 010 0", gnt, mem_we); end
        req = 3'b000;
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b010 || rdata !== 8'h3C)
            begin n_bad++; $display("FAIL wrrd_rdata: got rvalid %b rdata %h want 010 3c", rvalid, rdata); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [2:0] req_seq [6];
        logic [2:0] exp_gnt [6];
        logic [7:0] exp_dat [6];
        req_seq = '{3'b111, 3'b101, 3'b110, 3'b101, 3'b110, 3'b111};
        exp_gnt = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b100, 3'b010};
        exp_dat = '{8'h58,  8'h5B,  8'h58,  8'h5B,  8'h59,  8'h58};
        set_cmd(0, 1'b0, 8'h01, 8'h00);
        set_cmd(1, 1'b0, 8'h02, 8'h00);
        set_cmd(2, 1'b0, 8'h03, 8'h00);
        req = req_seq[0];
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++; if (gnt !== exp_gnt[k])
                begin n_bad++; $display("FAIL arb_gnt[%0d]: got %b want %b", k, gnt, exp_gnt[k]); end
            req = (k < 5) ? req_seq[k+1] : 3'b000;
            @(negedge clk);
            n_cmp++; if (rvalid !== exp_gnt[k] || rdata !== exp_dat[k])
                begin n_bad++; $display("FAIL arb_resp[%0d]: got rvalid %b rdata %h want %b %h",
                                        k, rvalid, rdata, exp_gnt[k], exp_dat[k]); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        set_cmd(1, 1'b0, 8'h00, 8'h00);
        req = 3'b010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (gnt !== 3'b010 || mem_addr !== 8'(i))
                begin n_bad++; $display("FAIL b2b_gnt[%0d]: got gnt %b addr %h want 010 %h", i, gnt, mem_addr, 8'(i)); end
            if (i < 3) addr[15:8] = 8'(i + 1);
            else       req = 3'b000;
            @(negedge clk);
            n_cmp++; if (rvalid !== 3'b010 || gnt !== 3'b000 || rdata !== (8'(i) ^ 8'h5A))
                begin n_bad++; $display("FAIL b2b_resp[%0d]: got rvalid %b gnt %b rdata %h want 010 000 %h",
                                        i, rvalid, gnt, rdata, 8'(i) ^ 8'h5A); end
        end
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b000 || gnt !== 3'b000)
            begin n_bad++; $display("FAIL b2b_idle: got rvalid %b gnt %b want 000 000", rvalid, gnt); end
    endtask

    task automatic test_reset_mid();
        set_cmd(0, 1'b0, 8'h10, 8'h00);
        req = 3'b001;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL rstmid_gnt: got %b want 001", gnt); end
        #1 reset = 1'b1;
        req = 3'b000;
        #1;
        n_cmp++; if (gnt !== 3'b000 || rvalid !== 3'b000 || mem_en !== 1'b0)
            begin n_bad++; $display("FAIL rstmid_async: got gnt %b rvalid %b en %b want 000 000 0", gnt, rvalid, mem_en); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b000 || gnt !== 3'b000)
            begin n_bad++; $display("FAIL rstmid_aborted: got rvalid %b gnt %b want 000 000", rvalid, gnt); end
        set_cmd(2, 1'b0, 8'h03, 8'h00);
        req = 3'b100;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b100) begin n_bad++; $display("FAIL rstmid_regnt: got %b want 100", gnt); end
        req = 3'b000;
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b100 || rdata !== 8'h59)
            begin n_bad++; $display("FAIL rstmid_resp: got rvalid %b rdata %h want 100 59", rvalid, rdata); end
        @(negedge clk);
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic run_read(input int p, input logic [7:0] a);
        set_cmd(p, 1'b0, a, 8'h00);
        req = 3'b000;
        req[p] = 1'b1;
        @(negedge clk);
        req = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stats();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (stat_cnt !== 48'd0) begin n_bad++; $display("FAIL stat_reset: got %h want 0", stat_cnt); end
        for (int i = 0; i < 3; i++) run_read(0, 8'h10);
        for (int i = 0; i < 2; i++) run_read(2, 8'h03);
        n_cmp++; if (stat_cnt[15:0] !== 16'd3)  begin n_bad++; $display("FAIL stat_p0: got %0d want 3", stat_cnt[15:0]); end
        n_cmp++; if (stat_cnt[31:16] !== 16'd0) begin n_bad++; $display("FAIL stat_p1: got %0d want 0", stat_cnt[31:16]); end
        n_cmp++; if (stat_cnt[47:32] !== 16'd2) begin n_bad++; $display("FAIL stat_p2: got %0d want 2", stat_cnt[47:32]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
